// File: rtl/instr_decoder_sync_if.sv
// ---------------------------------------------------------------------------
// instr_decoder_sync_if
//   Bundles the packet input channel and all decoder output channels
//   (filter memory, packetizer, filter instr-gen, ifmap memory, PE acks,
//   bad-PE error pulse) of the control-node instruction decoder.
//
//   Every channel uses the same valid/ready rule: a transfer completes on
//   a rising clock edge where valid and ready are both high. The producer
//   holds valid and keeps its data stable until that edge; the consumer
//   may raise or lower ready at any time, and a ready seen while valid is
//   low has no effect.
//
//   modport master : the decoder side (drives in_ready and all outputs)
//   modport slave  : the environment side (drives packets and readies)
// ---------------------------------------------------------------------------
interface instr_decoder_sync_if #(
    parameter int WIDTH  = 45,
    parameter int NUM_PE = 14
) ();
    // packet input
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    // filter memory write
    logic              fil_valid;
    logic              fil_ready;
    logic [WIDTH-2:0]  fil_data;
    // filter size to packetizer
    logic              pkz_valid;
    logic              pkz_ready;
    logic [1:0]        pkz_data;
    // filter instruction generator request
    logic              finst_valid;
    logic              finst_ready;
    logic [3:0]        finst_data;
    // ifmap memory write
    logic              ifm_valid;
    logic              ifm_ready;
    logic [WIDTH:0]    ifm_data;
    // per-PE acknowledge channels
    logic [NUM_PE-1:0] ack_valid;
    logic [NUM_PE-1:0] ack_ready;
    // error pulse for ack packets with an out-of-range PE id
    logic              err_bad_pe;

    modport master (
        input  in_valid, in_data,
        input  fil_ready, pkz_ready, finst_ready, ifm_ready, ack_ready,
        output in_ready,
        output fil_valid, fil_data,
        output pkz_valid, pkz_data,
        output finst_valid, finst_data,
        output ifm_valid, ifm_data,
        output ack_valid,
        output err_bad_pe
    );

    modport slave (
        output in_valid, in_data,
        output fil_ready, pkz_ready, finst_ready, ifm_ready, ack_ready,
        input  in_ready,
        input  fil_valid, fil_data,
        input  pkz_valid, pkz_data,
        input  finst_valid, finst_data,
        input  ifm_valid, ifm_data,
        input  ack_valid,
        input  err_bad_pe
    );
endinterface

// File: rtl/instr_decoder_sync.sv
// ---------------------------------------------------------------------------
// instr_decoder_sync
//   Control-node input decoder. Accepts one packet at a time and routes it:
//     in_data[0]=1, in_data[1]=1 : filter packet -> filter memory and
//                                  packetizer together, then filter
//                                  instruction generator
//     in_data[0]=1, in_data[1]=0 : ifmap packet  -> ifmap memory
//     in_data[0]=0               : PE ack        -> ack channel in_data[PE_W:1]
//   Tracks the current filter row (wrapping after the last row) and the
//   number of ifmap elements delivered so far for the current timestep.
//   An ack for a PE id >= NUM_PE is dropped and flagged by err_bad_pe.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        synchronous active-low reset
//   bus          instr_decoder_sync_if.master (packet in, all output channels)
//   dbg_state_o  current FSM state (IDLE=0, FIL=1, FINST=2, IFM=3, ACK=4)
//
// All outputs are registered: valids rise the cycle after a packet is
// accepted and in_ready is high only while the decoder is idle, so exactly
// one packet is ever in flight.
// ---------------------------------------------------------------------------
module instr_decoder_sync #(
    parameter int WIDTH    = 45,
    parameter int NUM_PE   = 14,
    parameter int PE_W     = 4,
    parameter int IF_CHUNK = 36,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_decoder_sync_if.master bus,
    output logic [2:0]          dbg_state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FIL   = 3'd1;
    localparam logic [2:0] ST_FINST = 3'd2;
    localparam logic [2:0] ST_IFM   = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    localparam logic [CNT_W-1:0] CHUNK      = CNT_W'(IF_CHUNK);
    localparam logic [PE_W:0]    NUM_PE_LIM = (PE_W + 1)'(NUM_PE);

    // state and output registers
    logic [2:0]        state_q,       state_d;
    logic              in_ready_q,    in_ready_d;
    logic              fil_valid_q,   fil_valid_d;
    logic              pkz_valid_q,   pkz_valid_d;
    logic              finst_valid_q, finst_valid_d;
    logic              ifm_valid_q,   ifm_valid_d;
    logic [NUM_PE-1:0] ack_valid_q,   ack_valid_d;
    logic              err_q,         err_d;
    logic [WIDTH-2:0]  fil_data_q,    fil_data_d;
    logic [1:0]        pkz_data_q,    pkz_data_d;
    logic [3:0]        finst_data_q,  finst_data_d;
    logic [WIDTH:0]    ifm_data_q,    ifm_data_d;
    logic [2:0]        filter_row_q,  filter_row_d;
    logic [1:0]        size_filter_q, size_filter_d;
    logic [CNT_W-1:0]  if_count_q,    if_count_d;
    logic              if_wrap_q,     if_wrap_d;

    // packet decode
    logic              accept;
    logic              pkt_ext;
    logic              pkt_fil;
    logic              pkt_ts;
    logic [1:0]        pkt_size;
    logic              fil_done;
    logic [5:0]        if_sz;
    logic [11:0]       if_sq_full;
    logic [CNT_W-1:0]  if_sq;
    logic              if_wrap;
    logic              if_done;
    logic [PE_W-1:0]   pe_id;
    logic              pe_ok;

    // handshakes
    logic              fil_hs;
    logic              pkz_hs;
    logic              finst_hs;
    logic              ifm_hs;
    logic              ack_hs;

    assign accept   = bus.in_valid & in_ready_q;
    assign pkt_ext  = bus.in_data[0];
    assign pkt_fil  = bus.in_data[1];
    assign pkt_ts   = bus.in_data[2];
    assign pkt_size = bus.in_data[4:3];

    // Last row of a filter is reached when row+1 equals the filter height
    // (2 + size_filter); both sides are kept at 3 bits.
    assign fil_done = (filter_row_q + 3'd1) == (3'd2 + {1'b0, pkt_size});

    // Ifmap: sz is the ifmap side length, sq the element count of one map.
    assign if_sz      = bus.in_data[8:3];
    assign if_sq_full = {6'd0, if_sz} * {6'd0, if_sz};
    assign if_sq      = CNT_W'(if_sq_full);
    assign if_wrap    = if_count_q >= if_sq;
    assign if_done    = if_wrap & pkt_ts;

    assign pe_id = bus.in_data[PE_W:1];
    assign pe_ok = {1'b0, pe_id} < NUM_PE_LIM;

    assign fil_hs   = fil_valid_q   & bus.fil_ready;
    assign pkz_hs   = pkz_valid_q   & bus.pkz_ready;
    assign finst_hs = finst_valid_q & bus.finst_ready;
    assign ifm_hs   = ifm_valid_q   & bus.ifm_ready;
    assign ack_hs   = |(ack_valid_q & bus.ack_ready);

    always_comb begin
        state_d       = state_q;
        fil_valid_d   = fil_valid_q;
        pkz_valid_d   = pkz_valid_q;
        finst_valid_d = finst_valid_q;
        ifm_valid_d   = ifm_valid_q;
        ack_valid_d   = ack_valid_q;
        err_d         = 1'b0;
        fil_data_d    = fil_data_q;
        pkz_data_d    = pkz_data_q;
        finst_data_d  = finst_data_q;
        ifm_data_d    = ifm_data_q;
        filter_row_d  = filter_row_q;
        size_filter_d = size_filter_q;
        if_count_d    = if_count_q;
        if_wrap_d     = if_wrap_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (pkt_ext && pkt_fil) begin
                        state_d       = ST_FIL;
                        fil_valid_d   = 1'b1;
                        pkz_valid_d   = 1'b1;
                        fil_data_d    = {fil_done, filter_row_q, bus.in_data[WIDTH-1:5]};
                        pkz_data_d    = pkt_size;
                        finst_data_d  = {fil_done, filter_row_q};
                        size_filter_d = pkt_size;
                        filter_row_d  = fil_done ? 3'd0 : filter_row_q + 3'd1;
                    end else if (pkt_ext) begin
                        state_d    = ST_IFM;
                        ifm_valid_d = 1'b1;
                        // size_filter here is the value latched by the
                        // most recent filter packet
                        ifm_data_d = {if_done, size_filter_q, bus.in_data[WIDTH-1:2]};
                        // the counter only advances once the write is taken
                        if_wrap_d  = if_wrap;
                    end else if (pe_ok) begin
                        state_d     = ST_ACK;
                        ack_valid_d = NUM_PE'(1) << pe_id;
                    end else begin
                        // dropped: flag it and stay ready for the next packet
                        err_d = 1'b1;
                    end
                end
            end
            ST_FIL: begin
                // the two channels complete independently, in any order
                if (fil_hs) fil_valid_d = 1'b0;
                if (pkz_hs) pkz_valid_d = 1'b0;
                if (!fil_valid_d && !pkz_valid_d) begin
                    state_d       = ST_FINST;
                    finst_valid_d = 1'b1;
                end
            end
            ST_FINST: begin
                if (finst_hs) begin
                    finst_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_IFM: begin
                if (ifm_hs) begin
                    ifm_valid_d = 1'b0;
                    if_count_d  = if_wrap_q ? CHUNK : if_count_q + CHUNK;
                    state_d     = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (ack_hs) begin
                    ack_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            fil_valid_q   <= 1'b0;
            pkz_valid_q   <= 1'b0;
            finst_valid_q <= 1'b0;
            ifm_valid_q   <= 1'b0;
            ack_valid_q   <= '0;
            err_q         <= 1'b0;
            fil_data_q    <= '0;
            pkz_data_q    <= '0;
            finst_data_q  <= '0;
            ifm_data_q    <= '0;
            filter_row_q  <= '0;
            size_filter_q <= '0;
            if_count_q    <= CHUNK;
            if_wrap_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            fil_valid_q   <= fil_valid_d;
            pkz_valid_q   <= pkz_valid_d;
            finst_valid_q <= finst_valid_d;
            ifm_valid_q   <= ifm_valid_d;
            ack_valid_q   <= ack_valid_d;
            err_q         <= err_d;
            fil_data_q    <= fil_data_d;
            pkz_data_q    <= pkz_data_d;
            finst_data_q  <= finst_data_d;
            ifm_data_q    <= ifm_data_d;
            filter_row_q  <= filter_row_d;
            size_filter_q <= size_filter_d;
            if_count_q    <= if_count_d;
            if_wrap_q     <= if_wrap_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.fil_valid   = fil_valid_q;
    assign bus.fil_data    = fil_data_q;
    assign bus.pkz_valid   = pkz_valid_q;
    assign bus.pkz_data    = pkz_data_q;
    assign bus.finst_valid = finst_valid_q;
    assign bus.finst_data  = finst_data_q;
    assign bus.ifm_valid   = ifm_valid_q;
    assign bus.ifm_data    = ifm_data_q;
    assign bus.ack_valid   = ack_valid_q;
    assign bus.err_bad_pe  = err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_instr_decoder_sync.sv
module tb_instr_decoder_sync;

    localparam int WIDTH    = 45;
    localparam int NUM_PE   = 14;
    localparam int PE_W     = 4;
    localparam int IF_CHUNK = 36;
    localparam int CNT_W    = 11;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    instr_decoder_sync_if #(.WIDTH(WIDTH), .NUM_PE(NUM_PE)) bus ();

    instr_decoder_sync #(
        .WIDTH(WIDTH), .NUM_PE(NUM_PE), .PE_W(PE_W),
        .IF_CHUNK(IF_CHUNK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Transaction view: which output transfers are still outstanding, plus
    // the running filter row, last filter size and ifmap element count.
    bit          m_rdy;
    bit          m_fil, m_pkz, m_finst, m_ifm, m_err, m_wrap;
    int          m_ack;
    int          m_row, m_size, m_count;
    logic [63:0] e_fil, e_pkz, e_finst, e_ifm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit vin, input logic [WIDTH-1:0] din,
                              input bit fr, input bit pr, input bit fir, input bit ir,
                              input logic [NUM_PE-1:0] ar);
        int  sz, sq, id;
        bit  done;
        m_err = 1'b0;
        if (rst) begin
            m_fil = 0; m_pkz = 0; m_finst = 0; m_ifm = 0; m_ack = -1;
            m_row = 0; m_size = 0; m_count = IF_CHUNK; m_rdy = 0;
            return;
        end
        if (m_rdy && vin) begin
            if (din[0] && din[1]) begin
                sz      = int'(din[4:3]);
                done    = (((m_row + 1) % 8) == ((2 + sz) % 8));
                e_fil   = (64'(din) >> 5) | (64'(m_row) << (WIDTH - 5)) | (64'(done) << (WIDTH - 2));
                e_pkz   = 64'(sz);
                e_finst = 64'(done) * 8 + 64'(m_row);
                m_size  = sz;
                m_row   = done ? 0 : (m_row + 1) % 8;
                m_fil   = 1; m_pkz = 1;
            end else if (din[0]) begin
                sz     = int'(din[8:3]);
                sq     = (sz * sz) % (1 << CNT_W);
                m_wrap = (m_count >= sq);
                done   = m_wrap && din[2];
                e_ifm  = (64'(din) >> 2) | (64'(m_size) << (WIDTH - 2)) | (64'(done) << WIDTH);
                m_ifm  = 1;
            end else begin
                id = int'(din[PE_W:1]);
                if (id < NUM_PE) m_ack = id;
                else m_err = 1'b1;
            end
        end else if (m_fil || m_pkz) begin
            if (m_fil && fr) m_fil = 0;
            if (m_pkz && pr) m_pkz = 0;
            if (!m_fil && !m_pkz) m_finst = 1;
        end else if (m_finst) begin
            if (fir) m_finst = 0;
        end else if (m_ifm) begin
            if (ir) begin
                m_ifm   = 0;
                m_count = m_wrap ? IF_CHUNK : (m_count + IF_CHUNK) % (1 << CNT_W);
            end
        end else if (m_ack >= 0) begin
            if (ar[m_ack]) m_ack = -1;
        end
        m_rdy = !(m_fil || m_pkz || m_finst || m_ifm || (m_ack >= 0));
    endtask

    task automatic compare_outputs();
        check("in_ready", 64'(bus.in_ready), 64'(m_rdy));
        check("fil_valid", 64'(bus.fil_valid), 64'(m_fil));
        if (m_fil) check("fil_data", 64'(bus.fil_data), e_fil);
        check("pkz_valid", 64'(bus.pkz_valid), 64'(m_pkz));
        if (m_pkz) check("pkz_data", 64'(bus.pkz_data), e_pkz);
        check("finst_valid", 64'(bus.finst_valid), 64'(m_finst));
        if (m_finst) check("finst_data", 64'(bus.finst_data), e_finst);
        check("ifm_valid", 64'(bus.ifm_valid), 64'(m_ifm));
        if (m_ifm) check("ifm_data", 64'(bus.ifm_data), e_ifm);
        check("ack_valid", 64'(bus.ack_valid), (m_ack >= 0) ? (64'd1 << m_ack) : 64'd0);
        check("err_bad_pe", 64'(bus.err_bad_pe), 64'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit rst, input bit vin, input logic [WIDTH-1:0] din,
                        input bit fr, input bit pr, input bit fir, input bit ir,
                        input logic [NUM_PE-1:0] ar);
        rst_n           = rst ? 1'b0 : 1'b1;
        bus.in_valid    = vin;
        bus.in_data     = din;
        bus.fil_ready   = fr;
        bus.pkz_ready   = pr;
        bus.finst_ready = fir;
        bus.ifm_ready   = ir;
        bus.ack_ready   = ar;
        model_step(rst, vin, din, fr, pr, fir, ir, ar);
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic hs_step();
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, '1);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] fil_pkt(input logic [1:0] size);
        logic [WIDTH-1:0] p;
        p = rand_word();
        p[0] = 1'b1; p[1] = 1'b1; p[4:3] = size;
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] ifm_pkt(input logic [5:0] sz, input logic ts);
        logic [WIDTH-1:0] p;
        p = rand_word();
        p[0] = 1'b1; p[1] = 1'b0; p[2] = ts; p[8:3] = sz;
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] ack_pkt(input logic [PE_W-1:0] id);
        logic [WIDTH-1:0] p;
        p = rand_word();
        p[0] = 1'b0; p[PE_W:1] = id;
        return p;
    endfunction

    // Sends one packet with every ready high and runs until the decoder is
    // idle again, capturing the finst_data and if_done values it produced.
    task automatic send(input logic [WIDTH-1:0] pkt, output int cap_finst, output int cap_done);
        cap_finst = -1;
        cap_done  = -1;
        check("send_in_ready", 64'(bus.in_ready), 64'd1);
        step(1'b0, 1'b1, pkt, 1'b1, 1'b1, 1'b1, 1'b1, '1);
        for (int k = 0; k < 8; k++) begin
            if (bus.finst_valid) cap_finst = int'(bus.finst_data);
            if (bus.ifm_valid) cap_done = int'(bus.ifm_data[WIDTH]);
            if (bus.in_ready) break;
            hs_step();
        end
        check("send_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    // ---------------- scoreboard / stimulus ----------------
    logic [3:0] exp_q[$];
    logic [0:0] done_q[$];

    initial begin
        int cf, cd;
        logic [WIDTH-1:0] d;
        bit rst, vin;

        bus.in_valid = 0; bus.in_data = '0; bus.fil_ready = 0; bus.pkz_ready = 0;
        bus.finst_ready = 0; bus.ifm_ready = 0; bus.ack_ready = '0;
        @(negedge clk);

        // reset held two cycles with arbitrary inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, rand_word(), 1'b1, 1'b0, 1'b1, 1'b0, NUM_PE'($urandom()));
            check("rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("rst_data_zero", 64'(bus.fil_data) | 64'(bus.ifm_data) | 64'(bus.finst_data) | 64'(bus.pkz_data), 64'd0);
        end
        check("rst_state_idle", 64'(dbg_state), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // 3x3 filter, row sequence then wrap
        exp_q = '{4'b0000, 4'b0001, 4'b1010, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            send(fil_pkt(2'd1), cf, cd);
            check("fil3x3_finst", 64'(cf), 64'(exp_q.pop_front()));
        end

        // pkz_ready one cycle behind fil_ready
        step(1'b0, 1'b1, fil_pkt(2'd1), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("late_fil_dropped", 64'(bus.fil_valid), 64'd0);
        check("late_pkz_held", 64'(bus.pkz_valid), 64'd1);
        check("late_no_finst", 64'(bus.finst_valid), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("late_finst_up", 64'(bus.finst_valid), 64'd1);
        hs_step();

        // ifmap 12x12, timestep end: done only when the count has covered 144
        done_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(ifm_pkt(6'd12, 1'b1), cf, cd);
            check("ifm12_done", 64'(cd), 64'(done_q.pop_front()));
        end

        // ack to PE 5 held while its ready is low (other readies high)
        step(1'b0, 1'b1, ack_pkt(4'd5), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            check("ack5_valid", 64'(bus.ack_valid), 64'h0020);
            check("ack5_busy", 64'(bus.in_ready), 64'd0);
            step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, ~NUM_PE'(14'h0020));
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, NUM_PE'(14'h0020));
        check("ack5_done", 64'(bus.ack_valid), 64'd0);

        // out-of-range PE id
        step(1'b0, 1'b1, ack_pkt(4'd15), 1'b0, 1'b0, 1'b0, 1'b0, '1);
        check("bad_pe_err", 64'(bus.err_bad_pe), 64'd1);
        check("bad_pe_no_ack", 64'(bus.ack_valid), 64'd0);
        check("bad_pe_ready", 64'(bus.in_ready), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("bad_pe_pulse", 64'(bus.err_bad_pe), 64'd0);

        // reset while an ifmap write is pending
        send(fil_pkt(2'd1), cf, cd);
        step(1'b0, 1'b1, ifm_pkt(6'd7, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("abort_ifm_valid", 64'(bus.ifm_valid), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send(ifm_pkt(6'd7, 1'b1), cf, cd);
        check("abort_count_36", 64'(cd), 64'd0);
        send(fil_pkt(2'd0), cf, cd);
        check("abort_row_0", 64'(cf), 64'd0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            vin = ($urandom_range(0, 1) == 1);
            d = rand_word();
            if ($urandom_range(0, 1) == 1) d[8:3] = 6'($urandom_range(0, 14));
            step(rst, vin, d,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 NUM_PE'($urandom()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
